// File: rtl/sweep_checker.sv
`default_nettype none
//============================================================================
// Module      : sweep_checker
// Description : Stimulus and response checker for the two-output "all"
//               combinational block. Walks {a,b,c,d} through all 16
//               vectors, holds each one for SETTLE cycles plus one sample
//               cycle, then captures {f2,f1}. Each capture is compared
//               against the golden equations
//                   g1 = ~d | b
//                   g2 = (b & ~c & d) | (a & ~d)
//               The checker accumulates a response map, a mismatch count
//               and the first failing vector, and reports pass/fail
//               through a start/done handshake.
// Ports       : clk              - single clock, rising edge
//               reset            - synchronous, active-high
//               start            - begin a sweep (honoured in IDLE/DONE)
//               f1, f2           - outputs of the block under check
//               a, b, c, d       - vector bits 3..0 driven to the block
//               busy             - sweep in progress
//               done             - sweep complete (level, until start/reset)
//               pass             - done with zero mismatches
//               err_count        - number of mismatching vectors (0..16)
//               first_fail_vec   - lowest mismatching vector
//               first_fail_valid - first_fail_vec is meaningful
//               resp_map         - {f2,f1} of vector v at bits [2v+1:2v]
// Revision    : 1.0 - initial release
//============================================================================
module sweep_checker #(
    parameter int SETTLE = 2    // cycles per vector before sampling, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        f1,
    input  logic        f2,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail_vec,
    output logic        first_fail_valid,
    output logic [31:0] resp_map
);

    // Settle counter terminal value; the counter runs 0..SETTLE-1.
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] c_LAST_VEC    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_vec;
    logic [3:0]  r_settle;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [4:0]  r_err;
    logic [3:0]  r_ffvec;
    logic        r_ffvalid;
    logic [31:0] r_map;

    logic        w_start_sweep;
    logic        w_settle_last;
    logic        w_sample;
    logic        w_last_vec;
    logic        w_g1;
    logic        w_g2;
    logic        w_mismatch;
    logic [4:0]  w_err_next;

    //------------------------------------------------------------------------
    // Golden model evaluated on the vector currently being driven.
    //------------------------------------------------------------------------
    assign w_g1 = ~r_vec[0] | r_vec[2];
    assign w_g2 = (r_vec[2] & ~r_vec[1] & r_vec[0]) | (r_vec[3] & ~r_vec[0]);

    // One count per vector, even when both outputs are wrong.
    assign w_mismatch = (f1 != w_g1) || (f2 != w_g2);
    assign w_err_next = r_err + {4'd0, w_mismatch};

    assign w_settle_last = (r_settle == c_SETTLE_LAST);
    assign w_last_vec    = (r_vec == c_LAST_VEC);
    assign w_sample      = (r_state == ST_SAMPLE);
    // start is ignored while a sweep is running.
    assign w_start_sweep = start &&
                           ((r_state == ST_IDLE) || (r_state == ST_DONE));

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (w_settle_last) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_next = w_last_vec ? ST_DONE : ST_DRIVE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Vector walk, settle timing and result accumulation
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec     <= 4'd0;
            r_settle  <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= 5'd0;
            r_ffvec   <= 4'd0;
            r_ffvalid <= 1'b0;
            r_map     <= 32'd0;
        end else begin
            if (w_start_sweep) begin
                r_vec     <= 4'd0;
                r_settle  <= 4'd0;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_pass    <= 1'b0;
                r_err     <= 5'd0;
                r_ffvec   <= 4'd0;
                r_ffvalid <= 1'b0;
                r_map     <= 32'd0;
            end

            // Counter wraps to zero on the DRIVE->SAMPLE edge so the next
            // vector always starts from a cleared count.
            if (r_state == ST_DRIVE) begin
                r_settle <= w_settle_last ? 4'd0 : r_settle + 4'd1;
            end

            if (w_sample) begin
                r_map[{r_vec, 1'b0} +: 2] <= {f2, f1};
                r_err <= w_err_next;
                if (w_mismatch && !r_ffvalid) begin
                    r_ffvec   <= r_vec;
                    r_ffvalid <= 1'b1;
                end
                if (w_last_vec) begin
                    // The vector stays at 15 in DONE; the sweep ends here
                    // so the 4-bit counter never wraps.
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (w_err_next == 5'd0);
                end else begin
                    r_vec <= r_vec + 4'd1;
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Outputs, all taken straight from registers
    //------------------------------------------------------------------------
    assign a                = r_vec[3];
    assign b                = r_vec[2];
    assign c                = r_vec[1];
    assign d                = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_vec   = r_ffvec;
    assign first_fail_valid = r_ffvalid;
    assign resp_map         = r_map;

endmodule
`default_nettype wire

// File: doc/sweep_checker.md
# sweep_checker

Self-checking stimulus and response stage for the two-output `all` combinational block.
- Upstream role: walks `{a,b,c,d}` through all 16 vectors, 0000 to 1111.
- Downstream role: after a programmable settle time, samples the block's `f1`/`f2` outputs and compares them against the golden equations.
- Results: accumulates a response map, a mismatch count and the first failing vector, then reports pass/fail with a start/done handshake.
- Purpose: replaces the open-loop counter bench so the combinational stage can be exercised and checked in hardware.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling. Legal range 1..15.

Ports, clock and reset first:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a sweep; sampled in IDLE or DONE only.
- `f1` input 1: `f1` from the checked block.
- `f2` input 1: `f2` from the checked block.
- `a` output 1: vector bit 3 (MSB).
- `b` output 1: vector bit 2.
- `c` output 1: vector bit 1.
- `d` output 1: vector bit 0 (LSB).
- `busy` output 1: sweep in progress.
- `done` output 1: sweep complete; level output, held until the next start or reset.
- `pass` output 1: `done && err_count==0`.
- `err_count` output 5: number of mismatching vectors, 0..16.
- `first_fail_vec` output 4: lowest vector that mismatched.
- `first_fail_valid` output 1: `first_fail_vec` is meaningful.
- `resp_map` output 32: captured `{f2,f1}` for vector v, stored at bits [2v+1:2v].

## Operation
- **Golden model:**
  - `g1 = ~d | b`
  - `g2 = (b & ~c & d) | (a & ~d)`
  - A vector mismatches if `f1!=g1` or `f2!=g2`; it counts once even if both outputs are wrong.
- **States:** IDLE, DRIVE, SAMPLE, DONE.
- **IDLE / DONE, `start=1`:**
  - go to DRIVE;
  - vec=0;
  - clear `err_count`, `resp_map`, `first_fail_*` and `done`;
  - set `busy`.
- **IDLE / DONE, `start=0`:** hold all outputs.
- **DRIVE:**
  - settle counter runs 0..SETTLE-1;
  - at SETTLE-1, go to SAMPLE;
  - `{a,b,c,d}` stays constant.
- **SAMPLE (one cycle):** on the exiting edge, register `{f2,f1}` into `resp_map[2v+1:2v]` and compare against golden.
- **On mismatch:**
  - `err_count` increments;
  - if `first_fail_valid==0`, load `first_fail_vec=v` and set `first_fail_valid`.
- **Leaving SAMPLE:**
  - if v==15, go to DONE: `busy=0`, `done=1`;
  - otherwise v=v+1 and go to DRIVE with the settle counter cleared.
- **Vector counter:** 4 bits; never wraps during a sweep, because the sweep ends at v==15.
- **`start` while busy:** ignored; no restart, no effect on results.
- **`err_count` width:** 5 bits; the maximum value is 16, so no saturation logic is needed.
- **Reset values** (all outputs registered):
  - `a`, `b`, `c`, `d` = 0;
  - `busy`, `done`, `pass`, `first_fail_valid` = 0;
  - `err_count` = 0, `first_fail_vec` = 0, `resp_map` = 0;
  - state = IDLE.
- **Reset mid-sweep:** same as power-on reset; partial results are discarded.
- **Reset and start together:** reset wins.

## Timing
- `start` sampled high at edge k: edge k enters DRIVE with `{a,b,c,d}=0000` visible after k.
- Each vector is held for SETTLE+1 cycles:
  - SETTLE cycles in DRIVE, plus 1 cycle in SAMPLE;
  - `f1`/`f2` are sampled at the end of the vector's last cycle, so the checked block has ≥SETTLE+1 cycles to settle.
- Vector v is driven from edge k+v·(SETTLE+1).
- `done` rises after edge k+16·(SETTLE+1); with SETTLE=2 that is 48 cycles.
- `busy` is high from edge k through the final SAMPLE cycle.
- `busy` and `done` are never high together.
- `err_count`, `resp_map` and `first_fail_*` are stable and valid whenever `done=1`.

## Test plan
- **Golden DUT connected, SETTLE=2:** pulse `start`. Expect:
  - `done` after 48 cycles;
  - `err_count=0`, `pass=1`, `first_fail_valid=0`;
  - `resp_map=32'h7F335D11`.
- **`f1` tied 0:** expect `err_count=12`, `first_fail_vec=0`, `first_fail_valid=1`, `pass=0`, `resp_map=32'h2A220800`.
- **`f2` tied 1** (`f1` from golden DUT): expect `err_count=10`, `first_fail_vec=0`, `pass=0`, `resp_map=32'hFFBBFFBB`.
- **`start` re-pulsed at cycle 20 of a sweep:** expect the sweep to be unaffected, `done` still at cycle 48, and identical results. A further `start` in DONE must clear the results and rerun a full 48-cycle sweep.
- **`reset` asserted at cycle 30:** expect all outputs 0 and state IDLE on the next edge. A following `start` must complete normally with golden results.
- **SETTLE=1 and SETTLE=15:** expect `done` at 32 and 256 cycles respectively, each vector held exactly SETTLE+1 cycles on `{a,b,c,d}`, and a golden `resp_map`.
